oam_dma_bus_ctrl: RTL and testbench

- Sits between the sm83 core and the single-ported 64 KiB memory.
- Owns the OAM DMA register (FF46) and sequences 160-byte OAM DMA copies from {src,00}..{src,9F} to FE00..FE9F.
- Holds HRAM (FF80–FFFE) internally, so HRAM stays CPU-accessible while DMA owns the memory bus.
- During DMA, all other CPU traffic is blocked.

---
 rtl/oam_dma_bus_ctrl_if.sv | 23 ++
 rtl/oam_dma_bus_ctrl.sv | 124 ++++++++++++
 tb/tb_oam_dma_bus_ctrl.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/oam_dma_bus_ctrl_if.sv
// CPU-side and memory-side bus bundle for oam_dma_bus_ctrl.
// The slave modport is the controller's view; the master modport is the CPU/memory side.
interface oam_dma_bus_ctrl_if;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_d_out;
    logic        cpu_write;
    logic [7:0]  cpu_d_in;
    logic [15:0] mem_addr;
    logic [7:0]  mem_d_out;
    logic        mem_write;
    logic [7:0]  mem_d_in;
    logic        dma_active;

    modport slave (
        input  cpu_addr, cpu_d_out, cpu_write, mem_d_in,
        output cpu_d_in, mem_addr, mem_d_out, mem_write, dma_active
    );

    modport master (
        output cpu_addr, cpu_d_out, cpu_write, mem_d_in,
        input  cpu_d_in, mem_addr, mem_d_out, mem_write, dma_active
    );
endinterface

// File: rtl/oam_dma_bus_ctrl.sv
// Memory bus arbiter between the CPU and a single-ported memory: owns the OAM DMA
// register, sequences 160-byte OAM copies, and keeps HRAM internal so it stays usable during DMA.
module oam_dma_bus_ctrl #(
    parameter logic [15:0] DMA_REG     = 16'hFF46,
    parameter logic [15:0] OAM_BASE    = 16'hFE00,
    parameter int unsigned DMA_LEN     = 160,
    parameter int unsigned START_DELAY = 1
) (
    input  logic              clk,
    input  logic              rst,
    oam_dma_bus_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, START, READ, WRITE} state_e;

    state_e     state_q, state_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] src_q, src_d;
    logic [7:0] dly_q, dly_d;
    logic [7:0] data_q, data_d;
    logic [7:0] resp_q, resp_d;
    logic       sel_q, sel_d;
    logic [7:0] hram_q [0:127];

    logic is_hram, is_reg, is_ext, trigger, active;

    // FF80..FFFE is HRAM; FFFF shares the top page but is EXT.
    always_comb begin
        is_hram = (bus.cpu_addr[15:7] == 9'h1FF) && (bus.cpu_addr[6:0] != 7'h7F);
        is_reg  = (bus.cpu_addr == DMA_REG);
        is_ext  = !is_hram && !is_reg;
        trigger = bus.cpu_write && is_reg;
        active  = (state_q == READ) || (state_q == WRITE);
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        src_d   = src_q;
        dly_d   = dly_q;
        data_d  = data_q;
        unique case (state_q)
            START: begin
                if (dly_q == 8'(START_DELAY - 1)) state_d = READ;
                else dly_d = dly_q + 8'd1;
            end
            READ: begin
                data_d  = bus.mem_d_in;
                state_d = WRITE;
            end
            WRITE: begin
                if (idx_q == 8'(DMA_LEN - 1)) begin
                    state_d = IDLE;
                end else begin
                    idx_d   = idx_q + 8'd1;
                    state_d = READ;
                end
            end
            default: ;
        endcase
        // A register write restarts from any state, including the last WRITE.
        if (trigger) begin
            src_d   = bus.cpu_d_out;
            idx_d   = '0;
            dly_d   = '0;
            state_d = START;
        end
    end

    always_comb begin
        bus.mem_addr   = bus.cpu_addr;
        bus.mem_d_out  = bus.cpu_d_out;
        bus.mem_write  = bus.cpu_write && is_ext;
        if (state_q == READ) begin
            bus.mem_addr  = {src_q, idx_q};
            bus.mem_write = 1'b0;
        end else if (state_q == WRITE) begin
            bus.mem_addr  = OAM_BASE + {8'h00, idx_q};
            bus.mem_d_out = data_q;
            bus.mem_write = 1'b1;
        end
        bus.dma_active = active;
        bus.cpu_d_in   = sel_q ? resp_q : bus.mem_d_in;
    end

    // Internal responses are captured on the falling edge to match memory read latency.
    always_comb begin
        sel_d  = 1'b1;
        resp_d = 8'hFF;
        if (is_hram)      resp_d = hram_q[bus.cpu_addr[6:0]];
        else if (is_reg)  resp_d = src_q;
        else if (!active) sel_d  = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            src_q   <= 8'hFF;
            dly_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            src_q   <= src_d;
            dly_q   <= dly_d;
            data_q  <= data_d;
        end
    end

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            resp_q <= 8'hFF;
            sel_q  <= 1'b1;
        end else begin
            resp_q <= resp_d;
            sel_q  <= sel_d;
        end
    end

    // HRAM contents survive reset.
    always_ff @(posedge clk) begin
        if (bus.cpu_write && is_hram) hram_q[bus.cpu_addr[6:0]] <= bus.cpu_d_out;
    end
endmodule

// File: tb/tb_oam_dma_bus_ctrl.sv
// Self-checking bench for oam_dma_bus_ctrl: memory model, cycle-level reference model,
// directed table, multi-cycle DMA sequences and randomized traffic.
module tb_oam_dma_bus_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    oam_dma_bus_ctrl_if bus ();

    oam_dma_bus_ctrl #(
        .DMA_REG    (16'hFF46),
        .OAM_BASE   (16'hFE00),
        .DMA_LEN    (160),
        .START_DELAY(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [7:0] mem     [0:65535];
    logic [7:0] ref_mem [0:65535];
    logic [7:0] hram_m  [0:127];

    int errors = 0, checks = 0, shown = 0;
    int cyc = 0, wcnt = 0, ff46_hits = 0;
    int k = 400;
    logic [7:0] src_m = 8'hFF, lat_m = 8'h00;

    logic        s_act, s_mw;
    logic [15:0] s_maddr;
    logic [7:0]  s_mdo, s_din;

    typedef struct {
        logic [15:0] a;
        logic [7:0]  d;
        logic        w;
        logic        cd;
        logic [7:0]  ed;
        logic        emw;
    } vec_t;
    vec_t tbl [13];

    function automatic logic is_hram_a(input logic [15:0] a);
        return (a >= 16'hFF80) && (a <= 16'hFFFE);
    endfunction

    function automatic logic is_ext_a(input logic [15:0] a);
        return !is_hram_a(a) && (a != 16'hFF46);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (shown < 40) $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
            shown++;
        end
    endtask

    task automatic setmem(input logic [15:0] a, input logic [7:0] v);
        mem[a]     = v;
        ref_mem[a] = v;
    endtask

    // One bus cycle: memory answers on the falling edge, writes land on the rising edge.
    task automatic cycle();
        @(negedge clk);
        bus.mem_d_in = mem[bus.mem_addr];
        #2;
        s_act   = bus.dma_active;
        s_mw    = bus.mem_write;
        s_maddr = bus.mem_addr;
        s_mdo   = bus.mem_d_out;
        s_din   = bus.cpu_d_in;
        @(posedge clk);
        if (s_mw === 1'b1) begin
            mem[s_maddr] = s_mdo;
            wcnt++;
            if (s_maddr == 16'hFF46) ff46_hits++;
        end
        cyc++;
        #1;
    endtask

    // k counts cycles since the last trigger write (trigger cycle = 0).
    task automatic step(input logic [15:0] a, input logic [7:0] d, input logic w);
        logic act, rd, wp;
        int i;
        logic [15:0] ea;
        logic [7:0] ed;
        bus.cpu_addr  = a;
        bus.cpu_d_out = d;
        bus.cpu_write = w;
        act = (k >= 2) && (k <= 321);
        rd  = act && (k % 2 == 0);
        wp  = act && (k % 2 == 1);
        i   = rd ? (k - 2) / 2 : (k - 3) / 2;
        cycle();
        ea = rd ? {src_m, 8'(i)} : (wp ? 16'hFE00 + 16'(i) : a);
        chk("dma_active", 32'(s_act), 32'(act));
        chk("mem_write", 32'(s_mw), 32'(act ? wp : (w && is_ext_a(a))));
        chk("mem_addr", 32'(s_maddr), 32'(ea));
        if (wp) chk("mem_d_out_dma", 32'(s_mdo), 32'(lat_m));
        else if (!act && w && is_ext_a(a)) chk("mem_d_out_cpu", 32'(s_mdo), 32'(d));
        if (!w) begin
            if (is_hram_a(a))       ed = hram_m[a[6:0]];
            else if (a == 16'hFF46) ed = src_m;
            else if (act)           ed = 8'hFF;
            else                    ed = ref_mem[a];
            chk("cpu_d_in", 32'(s_din), 32'(ed));
        end
        if (w && is_hram_a(a)) hram_m[a[6:0]] = d;
        if (w && is_ext_a(a) && !act) ref_mem[a] = d;
        if (rd) lat_m = ref_mem[{src_m, 8'(i)}];
        if (wp) ref_mem[16'hFE00 + 16'(i)] = lat_m;
        if (w && a == 16'hFF46) begin
            src_m = d;
            k = 1;
        end else if (k < 400) begin
            k++;
        end
    endtask

    initial begin
        int t0, rise, fall, w0, mism, act_cnt;
        logic [7:0] orig_c123;
        logic [15:0] ra;
        int r;

        rst = 1'b0;
        bus.cpu_addr  = 16'h1234;
        bus.cpu_d_out = 8'h00;
        bus.cpu_write = 1'b0;
        bus.mem_d_in  = 8'h00;
        for (int a = 0; a < 65536; a++) setmem(16'(a), 8'($urandom));
        for (int i = 0; i < 160; i++) begin
            setmem(16'hC000 + 16'(i), 8'(i) ^ 8'h5A);
            setmem(16'hD000 + 16'(i), 8'(i) ^ 8'hA5);
        end
        setmem(16'h0150, 8'h3E);
        orig_c123 = mem[16'hC123];

        // Reset state
        repeat (3) cycle();
        chk("rst_dma_active", 32'(bus.dma_active), 32'h0);
        chk("rst_mem_write", 32'(bus.mem_write), 32'h0);
        chk("rst_mem_addr_mirror", 32'(bus.mem_addr), 32'h1234);
        rst = 1'b1;
        step(16'h0000, 8'h00, 1'b0);

        for (int a = 16'hFF80; a <= 16'hFFFE; a++) step(16'(a), 8'(a) ^ 8'h33, 1'b1);

        // Idle decode and pass-through table
        tbl[0]  = '{16'hFF46, 8'h00, 1'b0, 1'b1, 8'hFF, 1'b0};
        tbl[1]  = '{16'hC000, 8'h12, 1'b1, 1'b0, 8'h00, 1'b1};
        tbl[2]  = '{16'hC000, 8'h00, 1'b0, 1'b1, 8'h12, 1'b0};
        tbl[3]  = '{16'hFF90, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b0};
        tbl[4]  = '{16'hFF90, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b0};
        tbl[5]  = '{16'hFFFF, 8'h3C, 1'b1, 1'b0, 8'h00, 1'b1};
        tbl[6]  = '{16'hFFFF, 8'h00, 1'b0, 1'b1, 8'h3C, 1'b0};
        tbl[7]  = '{16'hFF7F, 8'h99, 1'b1, 1'b0, 8'h00, 1'b1};
        tbl[8]  = '{16'hFF7F, 8'h00, 1'b0, 1'b1, 8'h99, 1'b0};
        tbl[9]  = '{16'hFFFE, 8'hEE, 1'b1, 1'b0, 8'h00, 1'b0};
        tbl[10] = '{16'hFFFE, 8'h00, 1'b0, 1'b1, 8'hEE, 1'b0};
        tbl[11] = '{16'h0150, 8'h00, 1'b0, 1'b1, 8'h3E, 1'b0};
        tbl[12] = '{16'hC000, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b1};
        for (int n = 0; n < 13; n++) begin
            w0 = wcnt;
            step(tbl[n].a, tbl[n].d, tbl[n].w);
            if (tbl[n].cd) chk("tbl_cpu_d_in", 32'(s_din), 32'(tbl[n].ed));
            chk("tbl_mem_write", 32'(s_mw), 32'(tbl[n].emw));
            chk("tbl_mem_addr", 32'(s_maddr), 32'(tbl[n].a));
            chk("tbl_write_pulses", 32'(wcnt - w0), 32'(tbl[n].emw));
        end

        // DMA from C0 with CPU traffic during the copy
        t0 = cyc;
        step(16'hFF46, 8'hC0, 1'b1);
        w0 = wcnt; rise = -1; fall = -1;
        for (int n = 1; n <= 330; n++) begin
            int c;
            c = cyc;
            if (n == 50) begin
                step(16'h0150, 8'h00, 1'b0);
                chk("dma_ext_read_ff", 32'(s_din), 32'hFF);
            end else if (n == 51) begin
                step(16'hC123, 8'h77, 1'b1);
            end else if (n == 52) begin
                step(16'hFF90, 8'hA5, 1'b1);
            end else if (n == 53) begin
                step(16'hFF90, 8'h00, 1'b0);
                chk("dma_hram_read", 32'(s_din), 32'hA5);
            end else begin
                step(16'h0000, 8'h00, 1'b0);
            end
            if (s_act && rise < 0) rise = c;
            if (!s_act && rise >= 0 && fall < 0) fall = c;
        end
        chk("dma_rise_cycle", 32'(rise - t0), 32'd2);
        chk("dma_fall_cycle", 32'(fall - t0), 32'd322);
        chk("dma_write_pulses", 32'(wcnt - w0), 32'd160);
        mism = 0;
        for (int i = 0; i < 160; i++) if (mem[16'hFE00 + 16'(i)] !== (8'(i) ^ 8'h5A)) mism++;
        chk("oam_copy_c0", 32'(mism), 32'd0);
        chk("dropped_ext_write", 32'(mem[16'hC123]), 32'(orig_c123));
        step(16'hFF46, 8'h00, 1'b0);
        chk("reg_read_c0", 32'(s_din), 32'hC0);

        // Restart at byte 40 with source D0
        step(16'hFF46, 8'hC0, 1'b1);
        for (int n = 1; n <= 81; n++) step(16'h0000, 8'h00, 1'b0);
        t0 = cyc;
        step(16'hFF46, 8'hD0, 1'b1);
        act_cnt = 0; fall = -1;
        for (int n = 1; n <= 330; n++) begin
            int c;
            c = cyc;
            step(16'h0000, 8'h00, 1'b0);
            if (n == 1) chk("restart_start_gap", 32'(s_act), 32'h0);
            if (s_act) act_cnt++;
            if (!s_act && n > 1 && fall < 0) fall = c;
        end
        chk("restart_active_len", 32'(act_cnt), 32'd320);
        chk("restart_fall_cycle", 32'(fall - t0), 32'd322);
        mism = 0;
        for (int i = 0; i < 160; i++) if (mem[16'hFE00 + 16'(i)] !== (8'(i) ^ 8'hA5)) mism++;
        chk("oam_copy_d0", 32'(mism), 32'd0);

        // Reset during the READ of byte 80
        step(16'hFF46, 8'hC0, 1'b1);
        for (int n = 1; n <= 161; n++) step(16'h0000, 8'h00, 1'b0);
        bus.cpu_addr = 16'h0000; bus.cpu_d_out = 8'h00; bus.cpu_write = 1'b0;
        rst = 1'b0;
        #1;
        chk("abort_dma_active", 32'(bus.dma_active), 32'h0);
        chk("abort_mem_write", 32'(bus.mem_write), 32'h0);
        repeat (3) cycle();
        rst = 1'b1;
        k = 400; src_m = 8'hFF;
        mism = 0;
        for (int i = 0; i < 80; i++) if (mem[16'hFE00 + 16'(i)] !== (8'(i) ^ 8'h5A)) mism++;
        for (int i = 80; i < 160; i++) if (mem[16'hFE00 + 16'(i)] !== (8'(i) ^ 8'hA5)) mism++;
        chk("oam_after_abort", 32'(mism), 32'd0);
        step(16'hFF46, 8'h00, 1'b0);
        chk("reg_read_after_reset", 32'(s_din), 32'hFF);
        step(16'hC005, 8'h00, 1'b0);
        chk("ext_read_after_reset", 32'(s_din), 32'h5F);

        // Randomized traffic including occasional triggers and restarts
        step(16'hFF46, 8'($urandom), 1'b1);
        for (int n = 0; n < 3000; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 2)       ra = 16'hFF46;
            else if (r < 8)  ra = 16'hFF46;
            else if (r < 35) ra = 16'hFF80 + 16'($urandom_range(0, 126));
            else if (r < 45) ra = 16'hFF00 + 16'($urandom_range(0, 255));
            else             ra = 16'($urandom_range(0, 65535));
            if (r < 2)       step(ra, 8'($urandom), 1'b1);
            else if (r < 8)  step(ra, 8'h00, 1'b0);
            else             step(ra, 8'($urandom), 1'($urandom_range(0, 1)));
        end
        for (int n = 0; n < 400; n++) step(16'h0000, 8'h00, 1'b0);
        mism = 0;
        for (int a = 0; a < 65536; a++) if (mem[a] !== ref_mem[a]) mism++;
        chk("mem_image", 32'(mism), 32'd0);
        chk("ff46_never_written", 32'(ff46_hits), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
